reg_byte_reader: RTL and testbench

- Reads a 16-bit register value and streams it onto the 8-bit data bus as byte transfers using a valid/ready handshake.
- Each byte carries a FunSel hint so that a receiving 16-bit register can rebuild the word with its write-low (101), write-high (110) or clear-high-and-write-low (100) operations.
- This is the read-out path, the counterpart of the byte-wise register write path. It sits between the register file outputs and the memory/bus interface.

---
 rtl/reg_byte_reader.sv | 115 +++++++++++
 tb/tb_reg_byte_reader.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/reg_byte_reader.sv
// Streams a captured 16-bit register value as two byte transfers (valid/ready), each tagged with a FunSel hint.
// Build option REG_BYTE_READER_COMPACT_EN: words with a zero high byte go out as one byte (FunSel 100).
module reg_byte_reader #(
   parameter bit HIGH_FIRST = 1'b0
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   input  logic [15:0] Q_in,
   output logic        Busy,
   output logic [7:0]  ByteOut,
   output logic        ByteValid,
   input  logic        ByteReady,
   output logic [2:0]  ByteFunSel,
   output logic        Done
);

   localparam logic [2:0] FS_LOW     = 3'b101;
   localparam logic [2:0] FS_HIGH    = 3'b110;
   localparam logic [2:0] FS_COMPACT = 3'b100;

   typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

   state_t      state, state_nxt;
   logic [15:0] word;
   logic        capture;
   logic        done_nxt;
   logic        compact;

`ifdef REG_BYTE_READER_COMPACT_EN
   assign compact = (word[15:8] == 8'h00);
`else
   assign compact = 1'b0;
`endif

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
         word  <= 16'h0000;
         Done  <= 1'b0;
      end else begin
         state <= state_nxt;
         Done  <= done_nxt;
         if (capture) word <= Q_in;
      end
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               state_nxt = FIRST;
               capture   = 1'b1;
            end
         end
         FIRST: begin
            if (ByteReady) begin
               if (compact) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = SECOND;
               end
            end
         end
         SECOND: begin
            if (ByteReady) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output bytes come straight from the held word, so they stay stable under backpressure.
   always_comb begin
      Busy       = 1'b0;
      ByteValid  = 1'b0;
      ByteOut    = 8'h00;
      ByteFunSel = 3'b000;
      case (state)
         FIRST: begin
            Busy      = 1'b1;
            ByteValid = 1'b1;
            if (compact) begin
               ByteOut    = word[7:0];
               ByteFunSel = FS_COMPACT;
            end else if (!HIGH_FIRST) begin
               ByteOut    = word[7:0];
               ByteFunSel = FS_LOW;
            end else begin
               ByteOut    = word[15:8];
               ByteFunSel = FS_HIGH;
            end
         end
         SECOND: begin
            Busy      = 1'b1;
            ByteValid = 1'b1;
            if (HIGH_FIRST) begin
               ByteOut    = word[7:0];
               ByteFunSel = FS_LOW;
            end else begin
               ByteOut    = word[15:8];
               ByteFunSel = FS_HIGH;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_reg_byte_reader.sv
// Bench for reg_byte_reader: both byte orders driven in lockstep, checked against a word/byte-list model.
module tb_reg_byte_reader;

   logic        Clock;
   logic        Reset;
   logic        Start;
   logic [15:0] Q_in;
   logic        ByteReady;
   logic [1:0]  busy, valid, done;
   logic [7:0]  bout [2];
   logic [2:0]  fsel [2];

   int checks = 0;
   int errors = 0;

   // Model: per instance, the word in flight, how many bytes it needs and how many were accepted.
   logic [15:0] mw   [2];
   int          mn   [2];
   int          mpos [2];
   logic        mdone[2];

   reg_byte_reader #(.HIGH_FIRST(1'b0)) dut0 (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Q_in(Q_in),
      .Busy(busy[0]), .ByteOut(bout[0]), .ByteValid(valid[0]),
      .ByteReady(ByteReady), .ByteFunSel(fsel[0]), .Done(done[0])
   );

   reg_byte_reader #(.HIGH_FIRST(1'b1)) dut1 (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Q_in(Q_in),
      .Busy(busy[1]), .ByteOut(bout[1]), .ByteValid(valid[1]),
      .ByteReady(ByteReady), .ByteFunSel(fsel[1]), .Done(done[1])
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int nbytes(input logic [15:0] w);
`ifdef REG_BYTE_READER_COMPACT_EN
      return (w[15:8] == 8'h00) ? 1 : 2;
`else
      return 2;
`endif
   endfunction

   // {FunSel, byte} for byte i of word w sent with order hf.
   function automatic logic [10:0] byte_at(input logic [15:0] w, input int hf, input int i);
      logic send_low;
      if (nbytes(w) == 1) return {3'b100, w[7:0]};
      send_low = ((i == 0) == (hf == 0));
      return send_low ? {3'b101, w[7:0]} : {3'b110, w[15:8]};
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         mw[k] = 16'h0000; mn[k] = 0; mpos[k] = 0; mdone[k] = 1'b0;
      end
   endtask

   task automatic model_edge(input logic st, input logic [15:0] q, input logic rdy);
      for (int k = 0; k < 2; k++) begin
         mdone[k] = 1'b0;
         if (mn[k] != 0) begin
            if (rdy) begin
               mpos[k]++;
               if (mpos[k] == mn[k]) begin
                  mn[k] = 0; mpos[k] = 0; mdone[k] = 1'b1;
               end
            end
         end else if (st) begin
            mw[k] = q; mn[k] = nbytes(q); mpos[k] = 0;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [10:0] eb;
      for (int k = 0; k < 2; k++) begin
         eb = (mn[k] != 0) ? byte_at(mw[k], k, mpos[k]) : 11'h000;
         chk({tag, (k == 0) ? "/lo_first busy" : "/hi_first busy"}, 16'(busy[k]), 16'(mn[k] != 0));
         chk({tag, (k == 0) ? "/lo_first valid" : "/hi_first valid"}, 16'(valid[k]), 16'(mn[k] != 0));
         chk({tag, (k == 0) ? "/lo_first done" : "/hi_first done"}, 16'(done[k]), 16'(mdone[k]));
         chk({tag, (k == 0) ? "/lo_first byte" : "/hi_first byte"}, {5'd0, fsel[k], bout[k]}, {5'd0, eb});
      end
   endtask

   task automatic step(input string tag, input logic st, input logic [15:0] q, input logic rdy);
      Start = st; Q_in = q; ByteReady = rdy;
      model_edge(st, q, rdy);
      @(posedge Clock); #1;
      check_outputs(tag);
   endtask

   initial begin
      logic [15:0] rq;
      Reset = 1'b0; Start = 1'b0; Q_in = 16'h0000; ByteReady = 1'b0;
      model_clear();
      repeat (2) @(posedge Clock);
      #1;
      check_outputs("reset");
      Reset = 1'b1;

      // Basic send, ready held high.
      step("basic", 1'b1, 16'hA55A, 1'b1);
      repeat (3) step("basic", 1'b0, 16'h0000, 1'b1);

      // Backpressure on the first byte.
      step("bp", 1'b1, 16'h1234, 1'b0);
      repeat (4) step("bp", 1'b0, 16'h0000, 1'b0);
      repeat (3) step("bp", 1'b0, 16'h0000, 1'b1);

      // Start and Q_in changes while busy must be ignored.
      step("ign", 1'b1, 16'hBEEF, 1'b0);
      step("ign", 1'b1, 16'h0000, 1'b0);
      step("ign", 1'b1, 16'h0000, 1'b1);
      repeat (3) step("ign", 1'b0, 16'h0000, 1'b1);

      // Back-to-back: next Start lands in the Done cycle.
      step("b2b", 1'b1, 16'hCAFE, 1'b1);
      step("b2b", 1'b0, 16'h0000, 1'b1);
      step("b2b", 1'b0, 16'h0000, 1'b1);
      step("b2b", 1'b1, 16'h0102, 1'b1);
      repeat (4) step("b2b", 1'b0, 16'h0000, 1'b1);

      // Asynchronous reset while the second byte is stalled.
      step("rst", 1'b1, 16'hDEAD, 1'b1);
      step("rst", 1'b0, 16'h0000, 1'b1);
      step("rst", 1'b0, 16'h0000, 1'b0);
      #3 Reset = 1'b0;
      #1;
      model_clear();
      check_outputs("midrst");
      @(posedge Clock); #1;
      Reset = 1'b1;
      check_outputs("midrst_rel");
      step("after_rst", 1'b1, 16'h0001, 1'b1);
      repeat (3) step("after_rst", 1'b0, 16'h0000, 1'b1);

      // Zero high byte: one or two bytes depending on the build.
      step("cmp", 1'b1, 16'h007F, 1'b1);
      repeat (3) step("cmp", 1'b0, 16'h0000, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         rq = 16'($urandom);
         if ($urandom_range(0, 3) == 0) rq[15:8] = 8'h00;
         step("rand", ($urandom_range(0, 2) == 0), rq, ($urandom_range(0, 3) != 0));
      end
      repeat (4) step("drain", 1'b0, 16'h0000, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
